// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT pipeline blocks.
//   PIX_W     : unsigned blur pixel width
//   DOG_W     : signed difference-of-Gaussian width (one extra sign bit)
//   DEF_COLS  : default pixels per row
//   DEF_ROWS  : default rows per frame
//   WIN_ROW_W : bits occupied by one row of a flattened 3x3 window
//   dog_t     : signed DoG sample type
package sift_pkg;

  localparam int PIX_W     = 9;
  localparam int DOG_W     = PIX_W + 1;
  localparam int DEF_COLS  = 640;
  localparam int DEF_ROWS  = 480;
  localparam int WIN_ROW_W = 3 * DOG_W;

  typedef logic signed [DOG_W-1:0] dog_t;

endpackage

// File: rtl/dog_line_buffer.sv
// One row of DoG samples held in a circular memory.
//   clk   : clock, write on rising edge
//   we    : write enable
//   addr  : column index, shared by read and write
//   wdata : sample written at addr when we=1
//   rdata : combinational read of the value at addr before this edge's write
// Depth and width are parameters so a vendor RAM macro can be dropped in here
// without touching the window logic.
module dog_line_buffer #(
  parameter  int DEPTH  = 640,
  parameter  int WIDTH  = 10,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the memory has no reset; its contents are only observed after a full
  // row has been written, and a reset port would stop it mapping onto a RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dog_window_gen.sv
// Difference-of-Gaussian 3x3 window generator.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : blur_a/blur_b carry the next raster-order pixel
//   blur_a     : finer-scale blur pixel (unsigned)
//   blur_b     : coarser-scale blur pixel (unsigned)
//   win_valid  : win/ctr_row/ctr_col hold a window this cycle
//   win        : 3x3 DoG window, element (i,j) at win[DOG_W*(3*i+j) +: DOG_W],
//                i=0 oldest row, j=0 oldest column
//   ctr_row    : row of the window centre
//   ctr_col    : column of the window centre
//   frame_done : pulses with the window of the frame's last pixel
// Pipeline: accept/subtract (stage 1) -> column shift window (stage 2) ->
// output register, so a pixel accepted at edge t shows its window after t+2.
module dog_window_gen
  import sift_pkg::*;
#(
  parameter  int COLS  = DEF_COLS,
  parameter  int ROWS  = DEF_ROWS,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [PIX_W-1:0]     blur_a,
  input  logic [PIX_W-1:0]     blur_b,
  output logic                 win_valid,
  output logic [9*DOG_W-1:0]   win,
  output logic [ROW_W-1:0]     ctr_row,
  output logic [COL_W-1:0]     ctr_col,
  output logic                 frame_done
);

  // Raster counters of the next pixel to be accepted.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Stage 1: registered difference and its raster position.
  logic             s1_valid_q, s1_valid_d;
  dog_t             s1_dog_q,   s1_dog_d;
  logic [COL_W-1:0] s1_col_q,   s1_col_d;
  logic [ROW_W-1:0] s1_row_q,   s1_row_d;

  // Line-buffer read data: row r-1 and row r-2 at the stage-1 column.
  dog_t lb1_rd, lb2_rd;

  // Stage 2: window columns [i][j] and the position/flags of the window.
  dog_t             win_reg_q [3][3];
  dog_t             win_reg_d [3][3];
  logic             s2_valid_q, s2_valid_d;
  logic             s2_last_q,  s2_last_d;
  logic [COL_W-1:0] s2_col_q,   s2_col_d;
  logic [ROW_W-1:0] s2_row_q,   s2_row_d;

  // Output registers.
  logic               win_valid_q,  win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [9*DOG_W-1:0] win_q,        win_d;
  logic [ROW_W-1:0]   ctr_row_q,    ctr_row_d;
  logic [COL_W-1:0]   ctr_col_q,    ctr_col_d;

  logic in_window;

  dog_line_buffer #(.DEPTH(COLS), .WIDTH(DOG_W)) u_lb1 (
    .clk   (clk),
    .we    (s1_valid_q),
    .addr  (s1_col_q),
    .wdata (s1_dog_q),
    .rdata (lb1_rd)
  );

  // The row that leaves lb1 moves down into lb2, giving a two-row history.
  dog_line_buffer #(.DEPTH(COLS), .WIDTH(DOG_W)) u_lb2 (
    .clk   (clk),
    .we    (s1_valid_q),
    .addr  (s1_col_q),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    col_d        = col_q;
    row_d        = row_q;
    s1_valid_d   = in_valid;
    s1_dog_d     = s1_dog_q;
    s1_col_d     = s1_col_q;
    s1_row_d     = s1_row_q;
    win_reg_d    = win_reg_q;
    s2_row_d     = s2_row_q;
    s2_col_d     = s2_col_q;
    win_valid_d  = s2_valid_q;
    frame_done_d = s2_last_q;
    win_d        = win_q;
    ctr_row_d    = ctr_row_q;
    ctr_col_d    = ctr_col_q;

    // Accept: advance raster position and form the signed difference.
    if (in_valid) begin
      s1_dog_d = dog_t'($signed({1'b0, blur_a}) - $signed({1'b0, blur_b}));
      s1_col_d = col_q;
      s1_row_d = row_q;
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    // Shift the window on every real pixel; border columns still have to pass
    // through so that the window is full once c reaches 2.
    if (s1_valid_q) begin
      for (int i = 0; i < 3; i++) begin
        win_reg_d[i][0] = win_reg_q[i][1];
        win_reg_d[i][1] = win_reg_q[i][2];
      end
      win_reg_d[0][2] = lb2_rd;
      win_reg_d[1][2] = lb1_rd;
      win_reg_d[2][2] = s1_dog_q;
    end

    // Windows touching rows/columns not yet written in this frame are dropped;
    // this is what keeps stale line-buffer data from ever reaching the output.
    in_window  = s1_valid_q && (s1_row_q >= ROW_W'(2)) && (s1_col_q >= COL_W'(2));
    s2_valid_d = in_window;
    s2_last_d  = in_window && (s1_row_q == ROW_W'(ROWS - 1)) &&
                 (s1_col_q == COL_W'(COLS - 1));
    if (in_window) begin
      s2_row_d = s1_row_q - ROW_W'(1);
      s2_col_d = s1_col_q - COL_W'(1);
    end

    if (s2_valid_q) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_d[WIN_ROW_W*i + DOG_W*j +: DOG_W] = win_reg_q[i][j];
        end
      end
      ctr_row_d = s2_row_q;
      ctr_col_d = s2_col_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_dog_q     <= '0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_reg_q[i][j] <= '0;
        end
      end
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_row_q     <= '0;
      s2_col_q     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_dog_q     <= s1_dog_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      win_reg_q    <= win_reg_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      s2_row_q     <= s2_row_d;
      s2_col_q     <= s2_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      ctr_row_q    <= ctr_row_d;
      ctr_col_q    <= ctr_col_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win        = win_q;
  assign ctr_row    = ctr_row_q;
  assign ctr_col    = ctr_col_q;

endmodule

// File: tb/tb_dog_window_gen.sv
// Self-checking bench for dog_window_gen on an 8x4 frame.
// Expected windows are built from whole-frame arrays of expected differences:
// every pixel (r,c) with r>=2, c>=2 owns the 3x3 neighbourhood of rows r-2..r
// and columns c-2..c, due three negedge samples after it is driven.
module tb_dog_window_gen;
  import sift_pkg::*;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [PIX_W-1:0]   blur_a = '0;
  logic [PIX_W-1:0]   blur_b = '0;
  logic               win_valid;
  logic [9*DOG_W-1:0] win;
  logic [ROW_W-1:0]   ctr_row;
  logic [COL_W-1:0]   ctr_col;
  logic               frame_done;

  dog_window_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .blur_a     (blur_a),
    .blur_b     (blur_b),
    .win_valid  (win_valid),
    .win        (win),
    .ctr_row    (ctr_row),
    .ctr_col    (ctr_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9*DOG_W-1:0] win;
    int                 row;
    int                 col;
    bit                 last;
    int                 due;
  } exp_t;

  typedef struct {
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic [DOG_W-1:0] dog;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [PIX_W-1:0] fa   [ROWS][COLS];
  logic [PIX_W-1:0] fb   [ROWS][COLS];
  logic [DOG_W-1:0] fexp [ROWS][COLS];

  int n_cmp = 0;
  int n_bad = 0;
  int n_win_rx = 0;
  int n_fd_rx  = 0;
  bit got_first = 0;
  logic [9*DOG_W-1:0] first_win;
  int first_row, first_col, last_row, last_col;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_win", win, 0);
      check("rst_ctr_row", ctr_row, 0);
      check("rst_ctr_col", ctr_col, 0);
    end else if (win_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_win", win_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc, mon_e.due);
        check("win", win, mon_e.win);
        check("ctr_row", ctr_row, mon_e.row);
        check("ctr_col", ctr_col, mon_e.col);
        check("frame_done", frame_done, mon_e.last);
        if (!got_first) begin
          got_first = 1;
          first_win = win;
          first_row = ctr_row;
          first_col = ctr_col;
        end
        last_row = ctr_row;
        last_col = ctr_col;
        n_win_rx++;
        if (frame_done) n_fd_rx++;
      end
    end else begin
      check("fd_without_win", frame_done, 0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missed_win", win_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    blur_a   = '0;
    blur_b   = '0;
  endtask

  task automatic drive_pixel(input int r, input int c);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    blur_a   = fa[r][c];
    blur_b   = fb[r][c];
    if (r >= 2 && c >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[DOG_W*(3*i+j) +: DOG_W] = fexp[r-2+i][c-2+j];
      e.row  = r - 1;
      e.col  = c - 1;
      e.last = (r == ROWS - 1) && (c == COLS - 1);
      e.due  = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  // Sends one frame in raster order; duty is the percent chance of a pixel in
  // any cycle. Stops after pixel (stop_r, stop_c) when that is in range.
  task automatic send_frame(input int duty, input int stop_r, input int stop_c);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        while (int'($urandom_range(99, 0)) >= duty) idle();
        drive_pixel(r, c);
        if (r == stop_r && c == stop_c) return;
      end
    end
  endtask

  task automatic drain();
    repeat (6) idle();
  endtask

  task automatic clear_rx();
    n_win_rx  = 0;
    n_fd_rx   = 0;
    got_first = 0;
  endtask

  // Expected difference straight from integer arithmetic.
  task automatic fill_arith();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        fexp[r][c] = DOG_W'(int'(fa[r][c]) - int'(fb[r][c]));
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        fa[r][c] = PIX_W'(8 * r + c);
        fb[r][c] = '0;
      end
    fill_arith();
  endtask

  task automatic check_frame_counts(input string tag, input int nwin, input int nfd);
    check({tag, "_win_count"}, n_win_rx, nwin);
    check({tag, "_fd_count"}, n_fd_rx, nfd);
  endtask

  vec_t vecs[6];
  logic [9*DOG_W-1:0] ramp_win;

  initial begin
    // Constant-frame vectors with hand-derived differences.
    vecs[0] = '{a: 9'd5,   b: 9'd6,   dog: 10'h3FF};
    vecs[1] = '{a: 9'd6,   b: 9'd5,   dog: 10'h001};
    vecs[2] = '{a: 9'd511, b: 9'd0,   dog: 10'h1FF};
    vecs[3] = '{a: 9'd0,   b: 9'd511, dog: 10'h201};
    vecs[4] = '{a: 9'd511, b: 9'd511, dog: 10'h000};
    vecs[5] = '{a: 9'd100, b: 9'd356, dog: 10'h300};

    ramp_win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        ramp_win[DOG_W*(3*i+j) +: DOG_W] = DOG_W'(8 * i + j);

    // Reset held with in_valid toggling: outputs must stay at zero.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      blur_a   = 9'd77;
      blur_b   = 9'd3;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (8) idle();
    check_frame_counts("post_reset_idle", 0, 0);

    // Table-driven constant frames.
    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          fa[r][c]   = vecs[v].a;
          fb[r][c]   = vecs[v].b;
          fexp[r][c] = vecs[v].dog;
        end
      clear_rx();
      send_frame(100, -1, -1);
      drain();
      check_frame_counts($sformatf("vec%0d", v), 12, 1);
    end

    // Gap-free ramp with hand checks of first and last window.
    fill_ramp();
    clear_rx();
    send_frame(100, -1, -1);
    drain();
    check_frame_counts("ramp", 12, 1);
    check("ramp_first_win", first_win, ramp_win);
    check("ramp_first_row", first_row, 1);
    check("ramp_first_col", first_col, 1);
    check("ramp_last_row", last_row, 2);
    check("ramp_last_col", last_col, 6);

    // Ramp with 30% input duty: same order, per-window latency still checked.
    clear_rx();
    send_frame(30, -1, -1);
    drain();
    check_frame_counts("ramp_gaps", 12, 1);
    check("gaps_first_win", first_win, ramp_win);
    check("gaps_last_col", last_col, 6);

    // Two frames back to back: no window for the wrap pixel.
    clear_rx();
    send_frame(100, -1, -1);
    send_frame(100, -1, -1);
    drain();
    check_frame_counts("wrap", 24, 2);

    // Random pixel values with random gaps.
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          fa[r][c] = PIX_W'($urandom_range(511, 0));
          fb[r][c] = PIX_W'($urandom_range(511, 0));
        end
      fill_arith();
      clear_rx();
      send_frame(f == 0 ? 100 : 50, -1, -1);
      drain();
      check_frame_counts($sformatf("rand%0d", f), 12, 1);
    end

    // Reset in the middle of a frame at pixel (2,5).
    fill_ramp();
    clear_rx();
    send_frame(100, 2, 5);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (3) idle();
    rst_n = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        fa[r][c] = 9'd1;
        fb[r][c] = 9'd0;
      end
    fill_arith();
    clear_rx();
    send_frame(100, -1, -1);
    drain();
    check_frame_counts("after_reset", 12, 1);
    check("after_reset_first_row", first_row, 1);
    check("after_reset_first_col", first_col, 1);
    check("pending_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
